// File: rtl/amm_burst_responder.sv
// amm_burst_responder: on-chip Avalon-MM burst slave that stands in for the DDR
// controller. Models init delay, write backpressure and fixed read latency.
module amm_burst_responder #(
  parameter int unsigned DDR_DATA_WIDTH = 64,
  parameter int unsigned DDR_ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned INIT_CYCLES    = 16,
  parameter int unsigned STALL_PERIOD   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      local_init_done,
  output logic                      amm_wait,
  input  logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  input  logic [5:0]                amm_burstcount,
  input  logic                      amm_wen,
  input  logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  input  logic                      amm_ren,
  output logic                      amm_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic                      prot_err
);

  localparam int unsigned DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned IDX_W       = MEM_DEPTH_LOG2;
  localparam int unsigned INIT_LAST   = (INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1;
  localparam int unsigned INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned STALL_LAST  = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;
  localparam int unsigned STALL_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned LAT_W       = 4;
  localparam int unsigned BEAT_W      = 6;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR_BURST,
    S_RD_WAIT,
    S_RD_DATA
  } state_t;

  state_t state_q, state_d;

  logic [INIT_W-1:0]         init_cnt_q;
  logic [LAT_W-1:0]          lat_q;
  logic [STALL_W-1:0]        stall_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [BEAT_W-1:0]         n_q;
  logic [IDX_W-1:0]          start_q;
  logic [DDR_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic              init_last_c;
  logic              lat_last_c;
  logic              stall_c;
  logic              rd_done_c;
  logic              wr_last_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic              rd_load_c;
  logic              prot_set_c;
  logic [BEAT_W-1:0] burst_n_c;
  logic [IDX_W-1:0]  mem_idx_c;

  // Upper word-address bits are deliberately ignored; the array aliases.
  if (DDR_ADDR_WIDTH > MEM_DEPTH_LOG2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^amm_addr[DDR_ADDR_WIDTH-1:MEM_DEPTH_LOG2];
  end

  assign init_last_c = (init_cnt_q == INIT_W'(INIT_LAST));
  assign lat_last_c  = (lat_q == LAT_W'(READ_LATENCY - 1));
  assign stall_c     = (STALL_PERIOD != 0) && (stall_q == STALL_W'(STALL_LAST));
  assign rd_done_c   = (beat_q == n_q);
  assign wr_last_c   = (beat_q == (n_q - BEAT_W'(1)));
  assign burst_n_c   = (amm_burstcount == '0) ? BEAT_W'(1) : amm_burstcount;
  assign mem_idx_c   = (state_q == S_IDLE) ? amm_addr[IDX_W-1:0]
                                           : start_q + IDX_W'(beat_q);

  // Waitrequest and handshake decode for the current cycle.
  always_comb begin
    amm_wait   = 1'b1;
    wr_acc_c   = 1'b0;
    rd_acc_c   = 1'b0;
    rd_load_c  = 1'b0;
    prot_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        amm_wait   = amm_wen & amm_ren;
        wr_acc_c   = amm_wen & ~amm_ren;
        rd_acc_c   = amm_ren & ~amm_wen;
        prot_set_c = (amm_wen & amm_ren) |
                     ((amm_wen ^ amm_ren) & (amm_burstcount == '0));
      end
      S_WR_BURST: begin
        amm_wait   = stall_c;
        wr_acc_c   = amm_wen & ~stall_c;
        prot_set_c = amm_ren;
      end
      S_RD_WAIT: rd_load_c = lat_last_c;
      S_RD_DATA: rd_load_c = ~rd_done_c;
      default: ;
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     if (init_last_c) state_d = S_IDLE;
      S_IDLE: begin
        if (wr_acc_c && (burst_n_c != BEAT_W'(1))) state_d = S_WR_BURST;
        else if (rd_acc_c)                         state_d = S_RD_WAIT;
      end
      S_WR_BURST: if (wr_acc_c && wr_last_c) state_d = S_IDLE;
      S_RD_WAIT:  if (lat_last_c) state_d = S_RD_DATA;
      S_RD_DATA:  if (rd_done_c) state_d = S_IDLE;
      default:    state_d = S_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Burst bookkeeping: init, latency, stall and beat counters plus latched start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
      lat_q      <= '0;
      stall_q    <= '0;
      beat_q     <= '0;
      n_q        <= '0;
      start_q    <= '0;
    end else begin
      if ((state_q == S_INIT) && !init_last_c) init_cnt_q <= init_cnt_q + INIT_W'(1);
      if (state_q == S_WR_BURST) stall_q <= stall_c ? '0 : stall_q + STALL_W'(1);
      else                       stall_q <= '0;
      if (state_q == S_RD_WAIT) lat_q <= lat_q + LAT_W'(1);
      if (wr_acc_c && (state_q == S_IDLE)) begin
        start_q <= amm_addr[IDX_W-1:0];
        n_q     <= burst_n_c;
        beat_q  <= BEAT_W'(1);
      end else if (rd_acc_c) begin
        start_q <= amm_addr[IDX_W-1:0];
        n_q     <= burst_n_c;
        beat_q  <= '0;
        lat_q   <= '0;
      end else if (wr_acc_c || rd_load_c) begin
        beat_q  <= beat_q + BEAT_W'(1);
      end
    end
  end

  // Registered outputs: init flag, read beat, sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      local_init_done <= 1'b0;
      amm_rvalid      <= 1'b0;
      amm_rdata       <= '0;
      prot_err        <= 1'b0;
    end else begin
      if ((state_q == S_INIT) && init_last_c) local_init_done <= 1'b1;
      amm_rvalid <= rd_load_c;
      if (rd_load_c) amm_rdata <= mem_q[mem_idx_c];
      if (prot_set_c) prot_err <= 1'b1;
    end
  end

  // Backing array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[mem_idx_c] <= amm_wdata;
  end

endmodule

// File: tb/tb_amm_burst_responder.sv
// Directed/randomized bench for amm_burst_responder against a word-array model.
module tb_amm_burst_responder;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int          LAT   = 4;
  localparam int          INIT  = 16;
  localparam int          STALL = 3;
  localparam int          DEPTH = 1024;

  logic          clk;
  logic          rst_n;
  logic          local_init_done;
  logic          amm_wait;
  logic [AW-1:0] amm_addr;
  logic [5:0]    amm_burstcount;
  logic          amm_wen;
  logic [DW-1:0] amm_wdata;
  logic          amm_ren;
  logic          amm_rvalid;
  logic [DW-1:0] amm_rdata;
  logic          prot_err;

  amm_burst_responder #(
    .DDR_DATA_WIDTH(DW),
    .DDR_ADDR_WIDTH(AW),
    .MEM_DEPTH_LOG2(10),
    .READ_LATENCY(LAT),
    .INIT_CYCLES(INIT),
    .STALL_PERIOD(STALL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .local_init_done(local_init_done),
    .amm_wait(amm_wait),
    .amm_addr(amm_addr),
    .amm_burstcount(amm_burstcount),
    .amm_wen(amm_wen),
    .amm_wdata(amm_wdata),
    .amm_ren(amm_ren),
    .amm_rvalid(amm_rvalid),
    .amm_rdata(amm_rdata),
    .prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf [64];
  logic          ref_perr;
  int            n_checks;
  int            n_pass;
  int            n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int a);
    logic [31:0] r;
    r = $urandom;
    return {r[31:10], 10'(a)};
  endfunction

  // Release reset and check the init window; ends at posedge+1.
  task automatic run_init();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_done_c0", 64'(local_init_done), 64'd0);
    check("init_wait_c0", 64'(amm_wait), 64'd1);
    for (int c = 1; c <= INIT; c++) begin
      @(posedge clk); #1;
      check((c < INIT) ? "init_done_low" : "init_done_high", 64'(local_init_done), 64'(c == INIT));
      check((c < INIT) ? "init_wait_high" : "init_wait_low", 64'(amm_wait), 64'(c != INIT));
    end
  endtask

  // Write burst of wbuf[0..n-1]; n_req==0 behaves as one beat. Starts/ends at posedge+1.
  task automatic write_burst(input int addr, input int n_req, input int gap_pct);
    int n, i, k, cyc;
    n = (n_req == 0) ? 1 : n_req;
    amm_addr       = mk_addr(addr);
    amm_burstcount = 6'(n_req);
    amm_wdata      = wbuf[0];
    amm_wen        = 1'b1;
    @(negedge clk);
    check("wr_beat0_wait", 64'(amm_wait), 64'd0);
    @(posedge clk);
    ref_mem[addr % DEPTH] = wbuf[0];
    if (n_req == 0) ref_perr = 1'b1;
    #1;
    i = 1; k = 1; cyc = 0;
    while (i < n && cyc < 500) begin
      amm_wen        = ($urandom_range(99, 0) >= 32'(gap_pct));
      amm_wdata      = wbuf[i];
      amm_addr       = mk_addr($urandom_range(1023, 0));
      amm_burstcount = 6'($urandom_range(63, 0));
      @(negedge clk);
      check("wr_stall", 64'(amm_wait), 64'((k % STALL) == 0));
      if (amm_wen && !amm_wait) begin
        ref_mem[(addr + i) % DEPTH] = wbuf[i];
        i++;
      end
      @(posedge clk); #1;
      k++; cyc++;
    end
    if (i < n) check("wr_timeout", 64'(i), 64'(n));
    amm_wen = 1'b0;
  endtask

  // Read burst and check latency, contiguity, data and wait release. Starts/ends at posedge+1.
  task automatic read_burst(input int addr, input int n);
    logic exp_v;
    amm_addr       = mk_addr(addr);
    amm_burstcount = 6'(n);
    amm_ren        = 1'b1;
    @(negedge clk);
    check("rd_accept_wait", 64'(amm_wait), 64'd0);
    @(posedge clk); #1;
    amm_ren = 1'b0;
    for (int c = 1; c <= LAT + n; c++) begin
      @(posedge clk); #1;
      exp_v = (c >= LAT) && (c < LAT + n);
      check("rd_valid", 64'(amm_rvalid), 64'(exp_v));
      check((c < LAT + n) ? "rd_wait_busy" : "rd_wait_release", 64'(amm_wait), 64'(c < LAT + n));
      if (exp_v) check("rd_data", amm_rdata, ref_mem[(addr + c - LAT) % DEPTH]);
      else if (c == LAT + n) check("rd_data_hold", amm_rdata, ref_mem[(addr + n - 1) % DEPTH]);
    end
  endtask

  initial begin
    int a, n;
    n_checks = 0; n_pass = 0; n_fail = 0;
    ref_perr = 1'b0;
    rst_n = 1'b0; amm_addr = '0; amm_burstcount = '0;
    amm_wen = 1'b0; amm_ren = 1'b0; amm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 64'(local_init_done), 64'd0);
    check("rst_wait", 64'(amm_wait), 64'd1);
    check("rst_rvalid", 64'(amm_rvalid), 64'd0);
    check("rst_rdata", amm_rdata, 64'd0);
    check("rst_perr", 64'(prot_err), 64'd0);
    run_init();

    // Basic write then readback with stalls and gaps.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hA0 + 64'(i);
    write_burst(16, 8, 20);
    read_burst(16, 8);
    check("perr_clean_basic", 64'(prot_err), 64'(ref_perr));

    // Wrap at the array end.
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
    write_burst(1022, 4, 0);
    read_burst(1022, 4);
    read_burst(0, 2);

    // Backpressure with frequent gaps.
    for (int i = 0; i < 16; i++) wbuf[i] = {$urandom, $urandom};
    write_burst(200, 16, 40);
    read_burst(200, 16);

    // Random bursts; reads issued the cycle right after the last write beat.
    for (int t = 0; t < 4; t++) begin
      a = $urandom_range(1023, 0);
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) wbuf[i] = {$urandom, $urandom};
      write_burst(a, n, 25);
      read_burst(a, n);
    end
    check("perr_clean_random", 64'(prot_err), 64'(ref_perr));

    // burstcount=0 behaves as a single beat and flags an error.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hA0 + 64'(i);
    write_burst(16, 8, 0);
    wbuf[0] = {$urandom, $urandom};
    write_burst(17, 0, 0);
    check("bc0_perr", 64'(prot_err), 64'd1);
    read_burst(16, 3);

    // Reset during the third read beat.
    amm_addr = mk_addr(16); amm_burstcount = 6'd8; amm_ren = 1'b1;
    @(negedge clk);
    check("mr_accept_wait", 64'(amm_wait), 64'd0);
    @(posedge clk); #1;
    amm_ren = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge clk); #1;
      check("mr_valid", 64'(amm_rvalid), 64'(c >= LAT));
      if (c >= LAT) check("mr_data", amm_rdata, ref_mem[16 + c - LAT]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_rvalid_rst", 64'(amm_rvalid), 64'd0);
    check("mr_rdata_rst", amm_rdata, 64'd0);
    check("mr_wait_rst", 64'(amm_wait), 64'd1);
    check("mr_done_rst", 64'(local_init_done), 64'd0);
    check("mr_perr_rst", 64'(prot_err), 64'd0);
    ref_perr = 1'b0;
    repeat (2) @(posedge clk);
    run_init();
    read_burst(16, 8);

    // wen and ren together in IDLE: stalled, error flagged, array untouched.
    amm_addr = mk_addr(16); amm_burstcount = 6'd1;
    amm_wdata = 64'hDEAD_BEEF_0000_0001;
    amm_wen = 1'b1; amm_ren = 1'b1;
    @(negedge clk);
    check("both_wait", 64'(amm_wait), 64'd1);
    @(posedge clk); #1;
    amm_wen = 1'b0; amm_ren = 1'b0;
    check("both_perr", 64'(prot_err), 64'd1);
    check("both_no_rvalid", 64'(amm_rvalid), 64'd0);
    read_burst(16, 2);
    check("perr_sticky", 64'(prot_err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
